shot_clock: RTL and testbench
=============================

# shot_clock

Autonomous game shot clock. A 4-bit counter counts down from a start value at a prescaled tick rate. An internal LFSR models random shot attempts: a shot reloads the clock. If no shot arrives before expiry, `buzz` sounds for a fixed period and the clock then reloads. The block is a self-contained leaf with no data inputs; it drives a display (`count`) and two annunciators (`shoot`, `buzz`).

## Interface
- `START_VAL`, 12: reload value of `count`; legal range 1..15.
- `TICK_DIV`, 4: clk cycles per countdown tick; ≥1 (1 = tick every cycle).
- `BUZZ_LEN`, 4: ticks the buzzer stays on after expiry; ≥1.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `SHOT_EN`, 1: 1 = shot generator active; 0 = shots never occur.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `count` out 4: remaining shot-clock value, registered.
- `shoot` out 1: one-clk pulse marking a shot attempt that reloads the clock, registered.
- `buzz` out 1: high for the whole expiry period, registered.

## Operation
- States:
  - RUN: counting down.
  - BUZZ: expired; buzzer on.
- Reset values:
  - state = RUN.
  - `count` = START_VAL.
  - `shoot` = 0.
  - `buzz` = 0.
  - prescaler = 0.
  - LFSR = LFSR_SEED.
  - buzz timer = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and then wraps.
  - Internal `tick` is true in any cycle where the prescaler equals TICK_DIV-1.
- LFSR:
  - 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1.
  - Shifts left; the feedback bit is `l[7]^l[5]^l[4]^l[3]` and enters bit 0.
  - Advances only on `tick`, in both states.
- Shot condition: `SHOT_EN` && `tick` && state == RUN && LFSR[2:0] == 3'b000. The LFSR value is sampled before it advances.
- RUN, on `tick`, with priority in this order:
  1. Shot condition true: `count` <= START_VAL and `shoot` <= 1.
  2. Otherwise, `count` == 1: `count` <= 0, `buzz` <= 1, buzz timer <= BUZZ_LEN-1, go to BUZZ.
  3. Otherwise: `count` <= `count` - 1.
- BUZZ, on `tick`:
  - If buzz timer == 0: `buzz` <= 0, `count` <= START_VAL, go to RUN.
  - Otherwise: buzz timer decrements.
  - Shot condition is ignored in BUZZ.
- `shoot` clears on every edge not covered by rule 1, so it is always exactly one clk wide.
- `count` never wraps below 0 and never exceeds START_VAL. The subtraction is 4-bit with no underflow path.
- A shot at `count` == 1 takes priority over expiry: the clock reloads and no buzz occurs.
- Without ticks, all outputs hold.

## Timing
- All outputs change only on rising `clk` edges, except asynchronous reset.
- First `tick` occurs at the TICK_DIV-th rising edge after `nrst` deasserts.
- With no shots, `count` steps START_VAL → 0 over START_VAL ticks (START_VAL×TICK_DIV cycles).
- `buzz` is high for BUZZ_LEN×TICK_DIV cycles. `count` shows START_VAL in the same cycle `buzz` falls.
- Full period without shots: (START_VAL+BUZZ_LEN)×TICK_DIV cycles.
- `shoot` rises in the same cycle `count` shows the reload value.
- Reset mid-operation, in any state: every output returns to its reset value immediately, with no dependence on `clk`.

## Structure
- Package `shot_pkg`:
  - state enum {RUN, BUZZ}.
  - LFSR width and tap constants.
  - 4-bit count width constant.
- Sub-module `shot_lfsr`:
  - Inputs: `clk`, `nrst`, `en` (`tick`), seed parameter.
  - Output: 8-bit state.
- The top module holds the prescaler, FSM, `count` register, buzz timer, and output registers.

## Test plan
- Reset hold: `nrst`=0 for 3 cycles, then clk running → `count`=12, `shoot`=0, `buzz`=0. Asserting `nrst` low between clk edges forces these values immediately.
- Countdown, SHOT_EN=0, defaults:
  - `count` reaches 11 at the 4th edge after release.
  - `count` reaches 0 with `buzz`=1 at edge 48.
  - `buzz` stays 1 for 16 cycles.
  - `count`=12 and `buzz`=0 at edge 64.
  - The sequence repeats with period 64.
- TICK_DIV=1, START_VAL=1, BUZZ_LEN=1, SHOT_EN=0 → `count`/`buzz` alternate 0/1 and 1/0 every cycle.
- Shot path, SHOT_EN=1, LFSR_SEED chosen with [2:0]=000 (e.g. 8'h08):
  - The first tick produces a one-cycle `shoot`=1.
  - `count` stays 12, with no decrement.
  - The golden model tracks LFSR-driven shots thereafter.
- Priority check: seed arranged so a shot coincides with `count`==1 → `shoot`=1, `count`=12, `buzz` stays 0.
- Mid-BUZZ reset: assert `nrst` during `buzz`=1 → `buzz`=0 and `count`=12 at once; after release the countdown restarts from 12.

Source files
------------

// File: rtl/shot_pkg.sv
// shot_pkg: shared types and constants for the shot clock.
//   state_e         - FSM encoding (RUN counting, BUZZ expired)
//   CNT_W           - width of the displayed shot-clock value
//   LFSR_W/TAPS     - shot generator LFSR width and feedback taps
//   LFSR_SHOT_MASK  - LFSR bits that must all be zero for a shot
package shot_pkg;

  typedef enum logic {RUN, BUZZ} state_e;

  localparam int CNT_W  = 4;
  localparam int LFSR_W = 8;

  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci LFSR: feedback is
  // l[7]^l[5]^l[4]^l[3], entering bit 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS      = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SHOT_MASK = 8'h07;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/shot_lfsr.sv
// shot_lfsr: 8-bit Fibonacci LFSR that advances only when en is high.
//   clk, nrst - clock, async active-low reset (loads SEED)
//   en        - advance enable (the prescaler tick)
//   state     - current LFSR contents
module shot_lfsr
  import shot_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/shot_clock.sv
// shot_clock: autonomous game shot clock.
//   clk   - single clock, rising edge
//   nrst  - async active-low reset
//   count - remaining shot-clock value (registered)
//   shoot - one-clk pulse when a random shot reloads the clock (registered)
//   buzz  - high for the whole expiry period (registered)
// A prescaler produces one tick every TICK_DIV clocks; all counting, the
// buzzer timer and the shot LFSR move only on that tick.
module shot_clock
  import shot_pkg::*;
#(
  parameter int                START_VAL = 12,
  parameter int                TICK_DIV  = 4,
  parameter int                BUZZ_LEN  = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5,
  parameter int                SHOT_EN   = 1
) (
  input  logic             clk,
  input  logic             nrst,
  output logic [CNT_W-1:0] count,
  output logic             shoot,
  output logic             buzz
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN) : 1;

  localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0]    B_LOAD = BW'(BUZZ_LEN - 1);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(START_VAL);

  // ---- prescaler ----
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = (presc_q == P_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick) presc_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // ---- shot generator ----
  logic [LFSR_W-1:0] lfsr;
  logic              shot_hit;

  shot_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .nrst  (nrst),
    .en    (tick),
    .state (lfsr)
  );

  state_e        state_q;
  logic [CNT_W-1:0] count_q;
  logic          shoot_q;
  logic          buzz_q;
  logic [BW-1:0] btmr_q;

  // The LFSR value seen here is the pre-advance value for this tick.
  assign shot_hit = (SHOT_EN != 0) && tick && (state_q == RUN) &&
                    ((lfsr & LFSR_SHOT_MASK) == '0);

  // ---- FSM with registered outputs ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RUN;
      count_q <= C_LOAD;
      shoot_q <= 1'b0;
      buzz_q  <= 1'b0;
      btmr_q  <= '0;
    end else begin
      shoot_q <= 1'b0;
      if (tick) begin
        case (state_q)
          RUN: begin
            if (shot_hit) begin
              // shot beats expiry even at count==1
              count_q <= C_LOAD;
              shoot_q <= 1'b1;
            end else if (count_q == CNT_W'(1)) begin
              count_q <= '0;
              buzz_q  <= 1'b1;
              btmr_q  <= B_LOAD;
              state_q <= BUZZ;
            end else if (count_q != '0) begin
              count_q <= count_q - CNT_W'(1);
            end
          end
          BUZZ: begin
            if (btmr_q == '0) begin
              buzz_q  <= 1'b0;
              count_q <= C_LOAD;
              state_q <= RUN;
            end else begin
              btmr_q <= btmr_q - BW'(1);
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign count = count_q;
  assign shoot = shoot_q;
  assign buzz  = buzz_q;

endmodule

// File: tb/tb_shot_clock.sv
// tb_shot_clock: runs five shot_clock configurations side by side against
// a tick-level reference model, with directed edge checks from the timing
// rules and randomly timed asynchronous resets.
module tb_shot_clock;

  localparam int N = 5;

  logic       clk;
  logic       nrst;
  logic [3:0] cnt_w [N];
  logic [N-1:0] sh_w, bz_w;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults, no shots        1: 1/1/1, no shots
  // 2: defaults, seed 08, shots  3: 1/1/1, seed 08, shots (shot at count==1)
  // 4: 7/3/2, seed A5, shots
  shot_clock #(.SHOT_EN(0)) u0 (.clk(clk), .nrst(nrst), .count(cnt_w[0]), .shoot(sh_w[0]), .buzz(bz_w[0]));
  shot_clock #(.START_VAL(1), .TICK_DIV(1), .BUZZ_LEN(1), .SHOT_EN(0)) u1 (.clk(clk), .nrst(nrst), .count(cnt_w[1]), .shoot(sh_w[1]), .buzz(bz_w[1]));
  shot_clock #(.LFSR_SEED(8'h08), .SHOT_EN(1)) u2 (.clk(clk), .nrst(nrst), .count(cnt_w[2]), .shoot(sh_w[2]), .buzz(bz_w[2]));
  shot_clock #(.START_VAL(1), .TICK_DIV(1), .BUZZ_LEN(1), .LFSR_SEED(8'h08), .SHOT_EN(1)) u3 (.clk(clk), .nrst(nrst), .count(cnt_w[3]), .shoot(sh_w[3]), .buzz(bz_w[3]));
  shot_clock #(.START_VAL(7), .TICK_DIV(3), .BUZZ_LEN(2), .LFSR_SEED(8'hA5), .SHOT_EN(1)) u4 (.clk(clk), .nrst(nrst), .count(cnt_w[4]), .shoot(sh_w[4]), .buzz(bz_w[4]));

  // Reference model: cycle position within a tick period, remaining buzzer
  // ticks, and the shot sequence as a plain 8-bit shift value.
  typedef struct {
    int sv, td, bl, en;
    logic [7:0] seed;
    int phase;     // clocks since last tick
    int cnt;
    int buzz_left; // ticks of buzzer still to run, 0 = not buzzing
    int shoot;
    logic [7:0] rnd;
  } m_t;

  m_t mdl [N];

  function automatic m_t m_reset(input m_t m);
    m.phase = 0; m.cnt = m.sv; m.buzz_left = 0; m.shoot = 0; m.rnd = m.seed;
    return m;
  endfunction

  function automatic m_t m_step(input m_t m);
    bit tick;
    tick = ((m.phase + 1) % m.td) == 0;
    m.phase = tick ? 0 : m.phase + 1;
    m.shoot = 0;
    if (tick) begin
      if (m.buzz_left == 0) begin
        if (m.en != 0 && m.rnd % 8 == 0) begin
          m.cnt = m.sv; m.shoot = 1;
        end else if (m.cnt == 1) begin
          m.cnt = 0; m.buzz_left = m.bl;
        end else if (m.cnt > 0) begin
          m.cnt = m.cnt - 1;
        end
      end else begin
        m.buzz_left = m.buzz_left - 1;
        if (m.buzz_left == 0) m.cnt = m.sv;
      end
      m.rnd = {m.rnd[6:0], m.rnd[7] ^ m.rnd[5] ^ m.rnd[4] ^ m.rnd[3]};
    end
    return m;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("cnt%0d", i),   int'(cnt_w[i]), mdl[i].cnt);
      chk($sformatf("shoot%0d", i), int'(sh_w[i]),  mdl[i].shoot);
      chk($sformatf("buzz%0d", i),  int'(bz_w[i]),  (mdl[i].buzz_left != 0) ? 1 : 0);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i),   int'(cnt_w[i]), mdl[i].sv);
      chk($sformatf("%s_shoot%0d", tag, i), int'(sh_w[i]),  0);
      chk($sformatf("%s_buzz%0d", tag, i),  int'(bz_w[i]),  0);
    end
  endtask

  // one rising edge, model follows, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    if (nrst) for (int i = 0; i < N; i++) mdl[i] = m_step(mdl[i]);
    @(negedge clk);
    chk_all();
  endtask

  // called just after a falling edge: drop reset between edges, check the
  // outputs respond without a clock, hold a few edges, release on a falling edge
  task automatic rst_pulse(input int hold);
    #($urandom_range(1, 3));
    nrst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) mdl[i] = m_reset(mdl[i]);
    chk_rst_vals("async");
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk_rst_vals("hold");
    nrst = 1'b1;
  endtask

  bit found;

  initial begin
    mdl[0].sv = 12; mdl[0].td = 4; mdl[0].bl = 4; mdl[0].en = 0; mdl[0].seed = 8'hA5;
    mdl[1].sv = 1;  mdl[1].td = 1; mdl[1].bl = 1; mdl[1].en = 0; mdl[1].seed = 8'hA5;
    mdl[2].sv = 12; mdl[2].td = 4; mdl[2].bl = 4; mdl[2].en = 1; mdl[2].seed = 8'h08;
    mdl[3].sv = 1;  mdl[3].td = 1; mdl[3].bl = 1; mdl[3].en = 1; mdl[3].seed = 8'h08;
    mdl[4].sv = 7;  mdl[4].td = 3; mdl[4].bl = 2; mdl[4].en = 1; mdl[4].seed = 8'hA5;
    for (int i = 0; i < N; i++) mdl[i] = m_reset(mdl[i]);

    // reset held for 3 clocks
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst_vals("rst");
    nrst = 1'b1;

    // directed timing from release, alongside the model
    for (int e = 1; e <= 130; e++) begin
      step();
      if (e == 3)   chk("A_cnt_e3", int'(cnt_w[0]), 12);
      if (e == 4)   chk("A_cnt_e4", int'(cnt_w[0]), 11);
      if (e == 47)  chk("A_buzz_e47", int'(bz_w[0]), 0);
      if (e == 48)  begin chk("A_cnt_e48", int'(cnt_w[0]), 0); chk("A_buzz_e48", int'(bz_w[0]), 1); end
      if (e == 63)  chk("A_buzz_e63", int'(bz_w[0]), 1);
      if (e == 64)  begin chk("A_cnt_e64", int'(cnt_w[0]), 12); chk("A_buzz_e64", int'(bz_w[0]), 0); end
      if (e == 112) begin chk("A_cnt_e112", int'(cnt_w[0]), 0); chk("A_buzz_e112", int'(bz_w[0]), 1); end
      if (e == 128) chk("A_cnt_e128", int'(cnt_w[0]), 12);
      if (e <= 6) begin
        chk("B_cnt_alt",  int'(cnt_w[1]), (e % 2 == 1) ? 0 : 1);
        chk("B_buzz_alt", int'(bz_w[1]),  (e % 2 == 1) ? 1 : 0);
      end
      if (e == 1) begin
        chk("D_shoot_e1", int'(sh_w[3]), 1);
        chk("D_cnt_e1",   int'(cnt_w[3]), 1);
        chk("D_buzz_e1",  int'(bz_w[3]), 0);
      end
      if (e == 3) chk("C_shoot_e3", int'(sh_w[2]), 0);
      if (e == 4) begin chk("C_shoot_e4", int'(sh_w[2]), 1); chk("C_cnt_e4", int'(cnt_w[2]), 12); end
      if (e == 5) chk("C_shoot_e5", int'(sh_w[2]), 0);
    end

    // reset in the middle of a buzz period
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      if (bz_w[0]) found = 1'b1;
    end
    chk("A_buzz_seen", int'(found), 1);
    rst_pulse(1);
    chk("A_midbuzz_cnt", int'(cnt_w[0]), 12);
    chk("A_midbuzz_buzz", int'(bz_w[0]), 0);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("A_restart_e%0d", e), int'(cnt_w[0]), (e < 4) ? 12 : 11);
    end

    // free run with randomly timed async resets
    repeat (3000) begin
      step();
      if ($urandom_range(0, 149) == 0) rst_pulse(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
